// File: rtl/riscv_pkg.sv
// Shared RV64 core definitions: datapath widths, ALU opcodes and the
// decoded control bundle carried down the pipeline.
package riscv_pkg;

    localparam int XLEN   = 64;
    localparam int REGW   = 5;
    localparam int ALUOPW = 4;

    localparam logic [ALUOPW-1:0] ALU_ADD  = 4'd0;
    localparam logic [ALUOPW-1:0] ALU_SUB  = 4'd1;
    localparam logic [ALUOPW-1:0] ALU_SLL  = 4'd2;
    localparam logic [ALUOPW-1:0] ALU_SLT  = 4'd3;
    localparam logic [ALUOPW-1:0] ALU_SLTU = 4'd4;
    localparam logic [ALUOPW-1:0] ALU_XOR  = 4'd5;
    localparam logic [ALUOPW-1:0] ALU_SRL  = 4'd6;
    localparam logic [ALUOPW-1:0] ALU_SRA  = 4'd7;
    localparam logic [ALUOPW-1:0] ALU_OR   = 4'd8;
    localparam logic [ALUOPW-1:0] ALU_AND  = 4'd9;

    typedef struct packed {
        logic [ALUOPW-1:0] alu_op;
        logic              alu_src;
        logic              reg_write;
        logic              mem_read;
        logic              mem_write;
        logic              mem_to_reg;
        logic              branch;
    } ctrl_t;

    localparam int CTRL_W = $bits(ctrl_t);

    // A bubble must be side-effect free: ADD with every enable cleared.
    localparam ctrl_t CTRL_NOP = '{alu_op: ALU_ADD, alu_src: 1'b0, reg_write: 1'b0,
                                   mem_read: 1'b0, mem_write: 1'b0, mem_to_reg: 1'b0,
                                   branch: 1'b0};

endpackage

// File: rtl/pipe_field_reg.sv
// One pipeline-register field group: reset > flush (bubble value) > stall (hold) > load.
module pipe_field_reg #(
    parameter int           W      = 1,
    parameter logic [W-1:0] BUBBLE = {W{1'b0}}
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         stall,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] q_r;

    // Field register with fixed priority; flush and stall never look at d.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_r <= {W{1'b0}};
        end else if (flush) begin
            q_r <= BUBBLE;
        end else if (stall) begin
            q_r <= q_r;
        end else begin
            q_r <= d;
        end
    end

    assign q = q_r;

endmodule

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register: captures decoded operands/control, resolves the
// ALU operand-b source and presents registered operands to execute.
module id_ex_pipe_reg
    import riscv_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic              id_valid,
    input  logic [XLEN-1:0]   id_pc,
    input  logic [XLEN-1:0]   id_rs1_data,
    input  logic [XLEN-1:0]   id_rs2_data,
    input  logic [XLEN-1:0]   id_imm,
    input  logic [REGW-1:0]   id_rs1,
    input  logic [REGW-1:0]   id_rs2,
    input  logic [REGW-1:0]   id_rd,
    input  logic [ALUOPW-1:0] id_alu_op,
    input  logic              id_alu_src,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              id_mem_write,
    input  logic              id_mem_to_reg,
    input  logic              id_branch,
    output logic              ex_valid,
    output logic [XLEN-1:0]   ex_pc,
    output logic [XLEN-1:0]   ex_op_a,
    output logic [XLEN-1:0]   ex_op_b,
    output logic [XLEN-1:0]   ex_rs2_data,
    output logic [REGW-1:0]   ex_rs1,
    output logic [REGW-1:0]   ex_rs2,
    output logic [REGW-1:0]   ex_rd,
    output logic [ALUOPW-1:0] ex_alu_op,
    output logic              ex_alu_src,
    output logic              ex_reg_write,
    output logic              ex_mem_read,
    output logic              ex_mem_write,
    output logic              ex_mem_to_reg,
    output logic              ex_branch
);

    ctrl_t            ctrl_in_s;
    ctrl_t            ctrl_out_s;
    logic [XLEN-1:0]  op_b_s;
    logic [3*REGW-1:0] idx_out_s;

    // An empty decode slot loads a control bubble so nothing reaches MEM/WB.
    always_comb begin
        ctrl_in_s = CTRL_NOP;
        if (id_valid) begin
            ctrl_in_s.alu_op     = id_alu_op;
            ctrl_in_s.alu_src    = id_alu_src;
            ctrl_in_s.reg_write  = id_reg_write;
            ctrl_in_s.mem_read   = id_mem_read;
            ctrl_in_s.mem_write  = id_mem_write;
            ctrl_in_s.mem_to_reg = id_mem_to_reg;
            ctrl_in_s.branch     = id_branch;
        end else begin
            ctrl_in_s = CTRL_NOP;
        end
    end

    // Operand b is passed full width; shift-amount masking belongs to the consumer.
    always_comb begin
        op_b_s = id_rs2_data;
        if (id_alu_src) begin
            op_b_s = id_imm;
        end else begin
            op_b_s = id_rs2_data;
        end
    end

    pipe_field_reg #(.W(1)) u_valid (
        .clk(clk), .rst(rst), .flush(flush), .stall(stall),
        .d(id_valid), .q(ex_valid)
    );

    pipe_field_reg #(.W(XLEN)) u_pc (
        .clk(clk), .rst(rst), .flush(flush), .stall(stall),
        .d(id_pc), .q(ex_pc)
    );

    pipe_field_reg #(.W(XLEN)) u_op_a (
        .clk(clk), .rst(rst), .flush(flush), .stall(stall),
        .d(id_rs1_data), .q(ex_op_a)
    );

    pipe_field_reg #(.W(XLEN)) u_op_b (
        .clk(clk), .rst(rst), .flush(flush), .stall(stall),
        .d(op_b_s), .q(ex_op_b)
    );

    pipe_field_reg #(.W(XLEN)) u_rs2_data (
        .clk(clk), .rst(rst), .flush(flush), .stall(stall),
        .d(id_rs2_data), .q(ex_rs2_data)
    );

    pipe_field_reg #(.W(3*REGW)) u_idx (
        .clk(clk), .rst(rst), .flush(flush), .stall(stall),
        .d({id_rs1, id_rs2, id_rd}), .q(idx_out_s)
    );

    pipe_field_reg #(.W(CTRL_W), .BUBBLE(CTRL_NOP)) u_ctrl (
        .clk(clk), .rst(rst), .flush(flush), .stall(stall),
        .d(ctrl_in_s), .q(ctrl_out_s)
    );

    assign ex_rs1        = idx_out_s[3*REGW-1:2*REGW];
    assign ex_rs2        = idx_out_s[2*REGW-1:REGW];
    assign ex_rd         = idx_out_s[REGW-1:0];
    assign ex_alu_op     = ctrl_out_s.alu_op;
    assign ex_alu_src    = ctrl_out_s.alu_src;
    assign ex_reg_write  = ctrl_out_s.reg_write;
    assign ex_mem_read   = ctrl_out_s.mem_read;
    assign ex_mem_write  = ctrl_out_s.mem_write;
    assign ex_mem_to_reg = ctrl_out_s.mem_to_reg;
    assign ex_branch     = ctrl_out_s.branch;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Directed bench for id_ex_pipe_reg: a behavioural model pushes the expected
// EX-stage image per edge into a queue, which is popped and compared after the edge.
module tb_id_ex_pipe_reg;
    import riscv_pkg::*;

    typedef struct packed {
        logic              valid;
        logic [XLEN-1:0]   pc;
        logic [XLEN-1:0]   op_a;
        logic [XLEN-1:0]   op_b;
        logic [XLEN-1:0]   rs2_data;
        logic [REGW-1:0]   rs1;
        logic [REGW-1:0]   rs2;
        logic [REGW-1:0]   rd;
        logic [ALUOPW-1:0] alu_op;
        logic              alu_src;
        logic              reg_write;
        logic              mem_read;
        logic              mem_write;
        logic              mem_to_reg;
        logic              branch;
    } out_t;

    logic              clk = 1'b0;
    logic              rst, stall, flush, id_valid;
    logic [XLEN-1:0]   id_pc, id_rs1_data, id_rs2_data, id_imm;
    logic [REGW-1:0]   id_rs1, id_rs2, id_rd;
    logic [ALUOPW-1:0] id_alu_op;
    logic              id_alu_src, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_branch;
    logic              ex_valid;
    logic [XLEN-1:0]   ex_pc, ex_op_a, ex_op_b, ex_rs2_data;
    logic [REGW-1:0]   ex_rs1, ex_rs2, ex_rd;
    logic [ALUOPW-1:0] ex_alu_op;
    logic              ex_alu_src, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_branch;

    out_t model;
    out_t sb[$];
    out_t held;
    int   n_vec = 0;
    int   n_err = 0;

    id_ex_pipe_reg dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .id_valid(id_valid),
        .id_pc(id_pc), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_alu_op(id_alu_op),
        .id_alu_src(id_alu_src), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg), .id_branch(id_branch),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_op_a(ex_op_a), .ex_op_b(ex_op_b),
        .ex_rs2_data(ex_rs2_data), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
        .ex_alu_op(ex_alu_op), .ex_alu_src(ex_alu_src), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg),
        .ex_branch(ex_branch)
    );

    always #5 clk = ~clk;

    function automatic out_t observed();
        out_t o;
        o = '{valid: ex_valid, pc: ex_pc, op_a: ex_op_a, op_b: ex_op_b, rs2_data: ex_rs2_data,
              rs1: ex_rs1, rs2: ex_rs2, rd: ex_rd, alu_op: ex_alu_op, alu_src: ex_alu_src,
              reg_write: ex_reg_write, mem_read: ex_mem_read, mem_write: ex_mem_write,
              mem_to_reg: ex_mem_to_reg, branch: ex_branch};
        return o;
    endfunction

    // Next EX image: rst > flush > stall > load; an invalid slot loads data but clears control.
    function automatic out_t next_model(out_t cur);
        out_t n;
        n = '0;
        if (rst === 1'b1 || flush === 1'b1) begin
            n = '0;
        end else if (stall === 1'b1) begin
            n = cur;
        end else begin
            n.pc       = id_pc;
            n.op_a     = id_rs1_data;
            n.op_b     = id_alu_src ? id_imm : id_rs2_data;
            n.rs2_data = id_rs2_data;
            n.rs1      = id_rs1;
            n.rs2      = id_rs2;
            n.rd       = id_rd;
            if (id_valid) begin
                n.valid      = 1'b1;
                n.alu_op     = id_alu_op;
                n.alu_src    = id_alu_src;
                n.reg_write  = id_reg_write;
                n.mem_read   = id_mem_read;
                n.mem_write  = id_mem_write;
                n.mem_to_reg = id_mem_to_reg;
                n.branch     = id_branch;
            end
        end
        return n;
    endfunction

    task automatic rand_inputs(input logic valid);
        id_valid      = valid;
        id_pc         = {$urandom, $urandom};
        id_rs1_data   = {$urandom, $urandom};
        id_rs2_data   = {$urandom, $urandom};
        id_imm        = {$urandom, $urandom};
        id_rs1        = REGW'($urandom);
        id_rs2        = REGW'($urandom);
        id_rd         = REGW'($urandom);
        id_alu_op     = ALUOPW'($urandom_range(9, 0));
        id_alu_src    = 1'($urandom);
        id_reg_write  = 1'($urandom);
        id_mem_read   = 1'($urandom);
        id_mem_write  = 1'($urandom);
        id_mem_to_reg = 1'($urandom);
        id_branch     = 1'($urandom);
    endtask

    task automatic x_inputs();
        id_valid = 1'bx; id_pc = 'x; id_rs1_data = 'x; id_rs2_data = 'x; id_imm = 'x;
        id_rs1 = 'x; id_rs2 = 'x; id_rd = 'x; id_alu_op = 'x;
        id_alu_src = 1'bx; id_reg_write = 1'bx; id_mem_read = 1'bx;
        id_mem_write = 1'bx; id_mem_to_reg = 1'bx; id_branch = 1'bx;
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_word(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Push the model's prediction, clock once, then pop and compare the full EX image.
    task automatic step(input string tag);
        out_t exp;
        out_t obs;
        model = next_model(model);
        sb.push_back(model);
        @(posedge clk);
        #1;
        obs = observed();
        n_vec++;
        if (sb.size() == 0) begin
            n_err++;
            $error("FAIL %s: scoreboard empty", tag);
        end else begin
            exp = sb.pop_front();
            assert (obs === exp) else begin
                n_err++;
                $error("FAIL %s: observed %h expected %h", tag, obs, exp);
            end
        end
    endtask

    initial begin
        model = '0;
        rst = 1'b1; stall = 1'b0; flush = 1'b0;
        rand_inputs(1'b1);
        @(negedge clk);

        // Reset with random inputs for two cycles.
        for (int i = 0; i < 2; i++) begin
            rand_inputs(1'b1);
            step("reset");
        end
        rst = 1'b0;

        // Arithmetic-shift load with immediate operand.
        rand_inputs(1'b1);
        id_rs1_data = 64'h8000_0000_0000_0001; id_imm = 64'd5; id_alu_src = 1'b1;
        id_alu_op = ALU_SRA; id_rd = 5'd7; id_reg_write = 1'b1;
        step("load_sra");
        check_word("sra_op_a", ex_op_a, 64'h8000_0000_0000_0001);
        check_word("sra_op_b", ex_op_b, 64'd5);
        check_word("sra_rd", {59'd0, ex_rd}, 64'd7);
        check_bit("sra_valid", ex_valid, 1'b1);
        held = observed();

        // Stall for three cycles while decode keeps changing.
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rand_inputs(1'b1);
            step("stall_hold");
        end
        check_word("stall_op_a_held", ex_op_a, held.op_a);
        stall = 1'b0;
        rand_inputs(1'b1);
        step("stall_release");

        // Flush over a valid store.
        flush = 1'b1;
        rand_inputs(1'b1);
        id_mem_write = 1'b1; id_reg_write = 1'b1;
        step("flush_store");
        check_bit("flush_valid", ex_valid, 1'b0);
        check_bit("flush_mem_write", ex_mem_write, 1'b0);
        check_bit("flush_reg_write", ex_reg_write, 1'b0);

        // Unknown decode values under flush, then under stall.
        x_inputs();
        step("flush_x");
        flush = 1'b0;
        rand_inputs(1'b1);
        step("load_before_stall_x");
        stall = 1'b1;
        x_inputs();
        step("stall_x");

        // Flush and stall together give a bubble.
        flush = 1'b1;
        rand_inputs(1'b1);
        step("flush_stall");
        flush = 1'b0; stall = 1'b0;
        rand_inputs(1'b1);
        step("load_before_rst");
        stall = 1'b1; rst = 1'b1;
        rand_inputs(1'b1);
        step("rst_stall");
        rst = 1'b0; stall = 1'b0;

        // Empty decode slot with write enable set.
        rand_inputs(1'b0);
        id_reg_write = 1'b1; id_alu_src = 1'b0; id_rs2_data = 64'h40;
        step("invalid_slot");
        check_bit("invalid_reg_write", ex_reg_write, 1'b0);
        check_bit("invalid_valid", ex_valid, 1'b0);

        // Register-operand b, and x0 destination passed through.
        rand_inputs(1'b1);
        id_alu_src = 1'b0; id_rs2_data = 64'hDEAD_BEEF_0000_1234; id_imm = 64'd99;
        id_rd = 5'd0; id_reg_write = 1'b1;
        step("rs2_operand_rd0");
        check_word("rs2_op_b", ex_op_b, 64'hDEAD_BEEF_0000_1234);
        check_bit("rd0_reg_write", ex_reg_write, 1'b1);

        // Randomised traffic with occasional stalls and flushes.
        for (int i = 0; i < 24; i++) begin
            stall = ($urandom_range(3, 0) == 0);
            flush = ($urandom_range(5, 0) == 0);
            rand_inputs(1'($urandom_range(3, 0) != 0));
            step("random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
